// File: rtl/fixed_point_mac.sv
// ============================================================================
// Module   : fixed_point_mac
// Purpose  : Pipelined signed fixed-point MAC; sums TAPS products per frame and
//            emits one scaled, saturated W-bit result per frame.
// Options  : MAC_ROUND_EN - round half up before the final shift.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fixed_point_mac #(
   parameter int W    = 16,
   parameter int F    = 8,
   parameter int TAPS = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clear,
   input  logic         in_valid,
   input  logic [W-1:0] in_a,
   input  logic [W-1:0] in_b,
   output logic         out_valid,
   output logic [W-1:0] out_result,
   output logic         out_sat,
   output logic         busy
);

   localparam int c_CNT_W = (TAPS > 1) ? $clog2(TAPS) : 1;
   localparam int c_ACC_W = 2 * W + $clog2(TAPS);
   localparam int c_SH_W  = c_ACC_W + 1;
   localparam logic [c_CNT_W-1:0]       c_LAST = c_CNT_W'(TAPS - 1);
   localparam logic signed [c_SH_W-1:0] c_MAX  = {{(c_SH_W-W+1){1'b0}}, {(W-1){1'b1}}};
   localparam logic signed [c_SH_W-1:0] c_MIN  = {{(c_SH_W-W+1){1'b1}}, {(W-1){1'b0}}};

   logic [c_CNT_W-1:0]        cnt_q, cnt_d;
   logic                      s1_valid_q, s1_first_q, s1_last_q;
   logic signed [W-1:0]       s1_a_q, s1_b_q;
   logic                      s2_valid_q, s2_first_q, s2_last_q;
   logic signed [2*W-1:0]     s2_prod_q;
   logic                      s3_valid_q, s3_last_q;
   logic signed [c_ACC_W-1:0] acc_q, acc_d;
   logic                      out_valid_q, out_sat_q;
   logic [W-1:0]              out_result_q;

   logic                      w_accept, w_first, w_last, w_fire, w_hi, w_lo;
   logic signed [2*W-1:0]     w_prod;
   logic signed [c_ACC_W-1:0] w_prod_ext;
   logic signed [c_SH_W-1:0]  w_acc_ext, w_scaled;
   logic [W-1:0]              w_clip;

   // A pair arriving together with clear is dropped.
   assign w_accept = in_valid & ~clear;
   assign w_first  = (cnt_q == '0);
   assign w_last   = (cnt_q == c_LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clear)
         cnt_d = '0;
      else if (w_accept)
         cnt_d = w_last ? '0 : cnt_q + c_CNT_W'(1);
   end

   assign w_prod     = s1_a_q * s1_b_q;
   assign w_prod_ext = c_ACC_W'(s2_prod_q);
   assign acc_d      = s2_first_q ? w_prod_ext : acc_q + w_prod_ext;

   assign w_acc_ext = {acc_q[c_ACC_W-1], acc_q};
`ifdef MAC_ROUND_EN
   localparam logic signed [c_SH_W-1:0] c_HALF = c_SH_W'(1) << (F - 1);
   logic signed [c_SH_W-1:0] w_rnd;
   assign w_rnd    = w_acc_ext + c_HALF;
   assign w_scaled = w_rnd >>> F;
`else
   assign w_scaled = w_acc_ext >>> F;
`endif

   assign w_hi   = (w_scaled > c_MAX);
   assign w_lo   = (w_scaled < c_MIN);
   assign w_clip = w_hi ? c_MAX[W-1:0] : (w_lo ? c_MIN[W-1:0] : w_scaled[W-1:0]);
   // clear also suppresses a result that would have left S3 on the same edge.
   assign w_fire = s3_valid_q & s3_last_q & ~clear;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q        <= '0;
         s1_valid_q   <= 1'b0;
         s1_first_q   <= 1'b0;
         s1_last_q    <= 1'b0;
         s1_a_q       <= '0;
         s1_b_q       <= '0;
         s2_valid_q   <= 1'b0;
         s2_first_q   <= 1'b0;
         s2_last_q    <= 1'b0;
         s2_prod_q    <= '0;
         s3_valid_q   <= 1'b0;
         s3_last_q    <= 1'b0;
         acc_q        <= '0;
         out_valid_q  <= 1'b0;
         out_result_q <= '0;
         out_sat_q    <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         s1_valid_q  <= w_accept;
         s2_valid_q  <= s1_valid_q & ~clear;
         s3_valid_q  <= s2_valid_q & ~clear;
         out_valid_q <= w_fire;
         if (w_accept) begin
            s1_a_q     <= in_a;
            s1_b_q     <= in_b;
            s1_first_q <= w_first;
            s1_last_q  <= w_last;
         end
         if (s1_valid_q) begin
            s2_prod_q  <= w_prod;
            s2_first_q <= s1_first_q;
            s2_last_q  <= s1_last_q;
         end
         if (s2_valid_q) begin
            acc_q     <= acc_d;
            s3_last_q <= s2_last_q;
         end
         if (w_fire) begin
            out_result_q <= w_clip;
            out_sat_q    <= w_hi | w_lo;
         end
      end
   end

   assign out_valid  = out_valid_q;
   assign out_result = out_result_q;
   assign out_sat    = out_sat_q;
   assign busy       = (cnt_q != '0) | s1_valid_q | s2_valid_q | s3_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_fixed_point_mac.sv
// ============================================================================
// Module   : tb_fixed_point_mac
// Purpose  : Self-checking bench for fixed_point_mac (TAPS=1 and TAPS=4 copies).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fixed_point_mac;

   localparam int W = 16;
   localparam int F = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        v1 = 1'b0, c1 = 1'b0, v4 = 1'b0, c4 = 1'b0;
   logic [15:0] a1 = '0, b1 = '0, a4 = '0, b4 = '0;
   logic        ov1, os1, bz1, ov4, os4, bz4;
   logic [15:0] or1, or4;

   fixed_point_mac #(.W(W), .F(F), .TAPS(1)) u_mac1 (
      .clk(clk), .rst(rst), .clear(c1), .in_valid(v1), .in_a(a1), .in_b(b1),
      .out_valid(ov1), .out_result(or1), .out_sat(os1), .busy(bz1));

   fixed_point_mac #(.W(W), .F(F), .TAPS(4)) u_mac4 (
      .clk(clk), .rst(rst), .clear(c4), .in_valid(v4), .in_a(a4), .in_b(b4),
      .out_valid(ov4), .out_result(or4), .out_sat(os4), .busy(bz4));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_total = 0;
   int n_bad   = 0;

   typedef struct {
      logic [15:0] res;
      logic        sat;
      int          due;
   } exp_t;

   exp_t   q1[$];
   exp_t   q4[$];
   longint pend4[$];
   int     pcyc4[$];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h want=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic longint mul(input logic [15:0] a, input logic [15:0] b);
      return longint'($signed(a)) * longint'($signed(b));
   endfunction

   // Real-valued frame sum -> scaled, clipped Q7.8 result.
   function automatic exp_t model(input longint s, input int due);
      exp_t   e;
      longint sc;
      longint half;
      half = longint'(1) << (F - 1);
`ifdef MAC_ROUND_EN
      sc = (s + half) >>> F;
`else
      sc = s >>> F;
      half = 0;
`endif
      if (sc > 32767) begin
         e.res = 16'h7FFF; e.sat = 1'b1;
      end else if (sc < -32768) begin
         e.res = 16'h8000; e.sat = 1'b1;
      end else begin
         e.res = sc[15:0]; e.sat = 1'b0;
      end
      e.due = due;
      return e;
   endfunction

   // Applies the current inputs to the model, then advances one clock.
   task automatic tick();
      int     t;
      longint s;
      t = cyc;
      if (rst || c1) begin
         while (q1.size() > 0 && q1[q1.size()-1].due >= t + 1) void'(q1.pop_back());
      end else if (v1) begin
         q1.push_back(model(mul(a1, b1), t + 4));
      end
      if (rst || c4) begin
         pend4.delete();
         while (q4.size() > 0 && q4[q4.size()-1].due >= t + 1) void'(q4.pop_back());
      end else if (v4) begin
         pend4.push_back(mul(a4, b4));
         if (pend4.size() == 4) begin
            s = 0;
            foreach (pend4[i]) s += pend4[i];
            q4.push_back(model(s, t + 4));
            pend4.delete();
         end
      end
      @(posedge clk);
      #1;
      v1 = 1'b0; c1 = 1'b0; v4 = 1'b0; c4 = 1'b0;
   endtask

   task automatic pair4(input logic [15:0] a, input logic [15:0] b);
      a4 = a; b4 = b; v4 = 1'b1;
      tick();
   endtask

   always @(negedge clk) begin : mon1
      exp_t e;
      if (q1.size() > 0 && q1[0].due < cyc) begin
         chk("t1_missing_due", cyc, q1[0].due);
         void'(q1.pop_front());
      end
      if (ov1) begin
         if (q1.size() == 0) chk("t1_spurious", ov1, 0);
         else begin
            e = q1.pop_front();
            chk("t1_res", or1, e.res);
            chk("t1_sat", os1, e.sat);
            chk("t1_lat", cyc, e.due);
         end
      end
   end

   always @(negedge clk) begin : mon4
      exp_t e;
      if (q4.size() > 0 && q4[0].due < cyc) begin
         chk("t4_missing_due", cyc, q4[0].due);
         void'(q4.pop_front());
      end
      if (ov4) begin
         pcyc4.push_back(cyc);
         if (q4.size() == 0) chk("t4_spurious", ov4, 0);
         else begin
            e = q4.pop_front();
            chk("t4_res", or4, e.res);
            chk("t4_sat", os4, e.sat);
            chk("t4_lat", cyc, e.due);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: cycle=%0d limit reached", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] va[6], vb[6], vr[6];
      logic        vs[6];
      logic [15:0] hold;
      logic [31:0] r;

      va[0] = 16'h0180; vb[0] = 16'h0340; vr[0] = 16'h04E0; vs[0] = 1'b0;
      va[1] = 16'h7F80; vb[1] = 16'h0540; vr[1] = 16'h7FFF; vs[1] = 1'b1;
      va[2] = 16'h8000; vb[2] = 16'h0200; vr[2] = 16'h8000; vs[2] = 1'b1;
      va[3] = 16'hFE80; vb[3] = 16'h0340; vr[3] = 16'hFB20; vs[3] = 1'b0;
      va[4] = 16'h0001; vb[4] = 16'h0080; vs[4] = 1'b0;
      va[5] = 16'hFFFF; vb[5] = 16'h0080; vs[5] = 1'b0;
`ifdef MAC_ROUND_EN
      vr[4] = 16'h0001; vr[5] = 16'h0000;
`else
      vr[4] = 16'h0000; vr[5] = 16'hFFFF;
`endif

      @(posedge clk); #1;
      repeat (3) tick();
      chk("rst_ov1", ov1, 0);  chk("rst_res1", or1, 0);
      chk("rst_sat1", os1, 0); chk("rst_busy1", bz1, 0);
      chk("rst_ov4", ov4, 0);  chk("rst_res4", or4, 0);
      chk("rst_sat4", os4, 0); chk("rst_busy4", bz4, 0);
      rst = 1'b0;
      tick();

      for (int i = 0; i < 6; i++) begin
         a1 = va[i]; b1 = vb[i]; v1 = 1'b1;
         tick();
         repeat (5) tick();
         chk("t1_dir_res", or1, vr[i]);
         chk("t1_dir_sat", os1, vs[i]);
      end

      repeat (40) begin
         v1 = 1'($urandom_range(0, 1));
         a1 = 16'($urandom); b1 = 16'($urandom);
         tick();
      end
      repeat (6) tick();

      pcyc4.delete();
      repeat (4) pair4(16'h0100, 16'h0100);
      pair4(16'h7F00, 16'h0200); pair4(16'h7F00, 16'h0200);
      pair4(16'h8100, 16'h0200); pair4(16'h8100, 16'h0200);
      repeat (8) tick();
      chk("b2b_pulses", pcyc4.size(), 2);
      if (pcyc4.size() == 2) chk("b2b_gap", pcyc4[1] - pcyc4[0], 4);
      chk("b2b_res", or4, 16'h0000);
      chk("b2b_sat", os4, 0);

      repeat (10) begin
         repeat (4) begin
            repeat ($urandom_range(0, 2)) tick();
            r = $urandom;
            a4 = r[31] ? r[15:0] : {{4{r[11]}}, r[11:0]};
            r = $urandom;
            b4 = r[31] ? r[15:0] : {{4{r[11]}}, r[11:0]};
            v4 = 1'b1;
            tick();
         end
      end
      repeat (8) tick();

      pcyc4.delete();
      pair4(16'h0300, 16'h0100); pair4(16'h0300, 16'h0100);
      chk("busy_mid", bz4, 1);
      hold = or4;
      c4 = 1'b1;
      tick();
      chk("clr_hold", or4, hold);
      chk("clr_ov", ov4, 0);
      chk("clr_busy", bz4, 0);
      repeat (4) pair4(16'h0100, 16'h0100);
      repeat (8) tick();
      chk("clr_pulses", pcyc4.size(), 1);
      chk("clr_res", or4, 16'h0400);

      pcyc4.delete();
      pair4(16'h0100, 16'h0100);
      a4 = 16'h7000; b4 = 16'h7000; v4 = 1'b1; c4 = 1'b1;
      tick();
      repeat (4) pair4(16'h0100, 16'h0100);
      repeat (8) tick();
      chk("clrv_pulses", pcyc4.size(), 1);
      chk("clrv_res", or4, 16'h0400);

      a1 = 16'h0180; b1 = 16'h0340; v1 = 1'b1;
      tick();
      repeat (5) tick();
      pair4(16'h0200, 16'h0100);
      a1 = 16'h0100; b1 = 16'h0100; v1 = 1'b1;
      pair4(16'h0200, 16'h0100);
      rst = 1'b1;
      tick();
      chk("mrst_res4", or4, 0);  chk("mrst_sat4", os4, 0);
      chk("mrst_ov4", ov4, 0);   chk("mrst_busy4", bz4, 0);
      chk("mrst_res1", or1, 0);  chk("mrst_busy1", bz1, 0);
      rst = 1'b0;
      tick();
      pcyc4.delete();
      pair4(16'h0180, 16'h0200); pair4(16'hFF00, 16'h0100);
      pair4(16'h0040, 16'h0400); pair4(16'h0100, 16'hFE00);
      repeat (8) tick();
      chk("mrst_pulses", pcyc4.size(), 1);

      chk("q1_drained", q1.size(), 0);
      chk("q4_drained", q4.size(), 0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
